// File: rtl/prescaled_cnt.sv
// prescaled_cnt: modulo counter stepped by an internal prescaler clock enable.
// A step happens after PRESCALE enabled clk cycles; out runs 0..MODULO-1 and wraps.
// tick marks each step and tc marks each wrapping step, both for one cycle.
// A synchronous load takes priority over a step, and values at or above
// MODULO load as MODULO-1.
// Optional feature macro: CNT_DOWN_EN adds the 'up' port for bidirectional counting;
// without it the counter counts up only.
module prescaled_cnt #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 10,
   parameter int unsigned MODULO   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
`ifdef CNT_DOWN_EN
   input  logic             up,
`endif
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             tc
);

   localparam int unsigned     PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] O_MAX = WIDTH'(MODULO - 1);
   localparam logic [WIDTH:0]  MOD_X  = (WIDTH + 1)'(MODULO);

   logic [PW-1:0]    pcnt;
   logic [PW-1:0]    pcnt_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             tick_nxt;
   logic             tc_nxt;
   logic             step;
   logic             dir;

   // Next-state: load beats step; step wraps out modulo MODULO in the selected direction
   always_comb begin
`ifdef CNT_DOWN_EN
      dir = up;
`else
      dir = 1'b1;
`endif
      step     = en && (pcnt == P_LAST);
      pcnt_nxt = pcnt;
      out_nxt  = out;
      tick_nxt = 1'b0;
      tc_nxt   = 1'b0;
      if (load) begin
         pcnt_nxt = '0;
         out_nxt  = ({1'b0, load_val} >= MOD_X) ? O_MAX : load_val;
      end else if (en) begin
         if (step) begin
            pcnt_nxt = '0;
            tick_nxt = 1'b1;
            if (dir) begin
               if (out >= O_MAX) begin
                  out_nxt = '0;
                  tc_nxt  = 1'b1;
               end else begin
                  out_nxt = out + WIDTH'(1);
               end
            end else begin
               if (out == '0) begin
                  out_nxt = O_MAX;
                  tc_nxt  = 1'b1;
               end else begin
                  out_nxt = out - WIDTH'(1);
               end
            end
         end else begin
            pcnt_nxt = pcnt + PW'(1);
         end
      end
   end

   // State and output registers; reset clears all progress immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
         out  <= '0;
         tick <= 1'b0;
         tc   <= 1'b0;
      end else begin
         pcnt <= pcnt_nxt;
         out  <= out_nxt;
         tick <= tick_nxt;
         tc   <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_prescaled_cnt.sv
// Directed self-checking bench for prescaled_cnt (three parameterisations).
module tb_prescaled_cnt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en1, load1, tick1, tc1;
   logic [3:0] lv1, out1;
   logic       en2, load2, tick2, tc2;
   logic [3:0] lv2, out2;
   logic       en3, load3, tick3, tc3;
   logic [3:0] lv3, out3;
   logic       up2;

   int checks   = 0;
   int failures = 0;

   // defaults: WIDTH=4, PRESCALE=10, MODULO=16
   prescaled_cnt dut1 (
      .clk(clk), .rst(rst), .en(en1),
`ifdef CNT_DOWN_EN
      .up(1'b1),
`endif
      .load(load1), .load_val(lv1), .out(out1), .tick(tick1), .tc(tc1)
   );

   prescaled_cnt #(.WIDTH(4), .PRESCALE(1), .MODULO(10)) dut2 (
      .clk(clk), .rst(rst), .en(en2),
`ifdef CNT_DOWN_EN
      .up(up2),
`endif
      .load(load2), .load_val(lv2), .out(out2), .tick(tick2), .tc(tc2)
   );

   prescaled_cnt #(.WIDTH(4), .PRESCALE(3), .MODULO(12)) dut3 (
      .clk(clk), .rst(rst), .en(en3),
`ifdef CNT_DOWN_EN
      .up(1'b1),
`endif
      .load(load3), .load_val(lv3), .out(out3), .tick(tick3), .tc(tc3)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      en1 = 1'b0; load1 = 1'b0; lv1 = 4'd0;
      en2 = 1'b0; load2 = 1'b0; lv2 = 4'd0;
      en3 = 1'b0; load3 = 1'b0; lv3 = 4'd0;
      up2 = 1'b1;
      repeat (3) cyc();
      checks++;
      if ({out1, tick1, tc1} !== 6'h00) begin
         $display("FAIL reset_dut1 got=%h exp=00 (out,tick,tc)", {out1, tick1, tc1});
         failures++;
      end
      checks++;
      if ({out2, tick2, tc2} !== 6'h00) begin
         $display("FAIL reset_dut2 got=%h exp=00 (out,tick,tc)", {out2, tick2, tc2});
         failures++;
      end
      checks++;
      if ({out3, tick3, tc3} !== 6'h00) begin
         $display("FAIL reset_dut3 got=%h exp=00 (out,tick,tc)", {out3, tick3, tc3});
         failures++;
      end
      rst = 1'b1;
   endtask

   task automatic test_count_up();
      logic [3:0] eo;
      logic       et, ec;
      int         tc_seen;
      tc_seen = 0;
      en1 = 1'b1;
      for (int c = 1; c <= 170; c++) begin
         cyc();
         eo = 4'((c / 10) % 16);
         et = (c % 10 == 0);
         ec = et && (eo == 4'd0);
         if (tc1 === 1'b1) tc_seen++;
         checks++;
         if ({out1, tick1, tc1} !== {eo, et, ec}) begin
            $display("FAIL count_up c=%0d got=%h exp=%h (out,tick,tc)", c, {out1, tick1, tc1}, {eo, et, ec});
            failures++;
         end
      end
      checks++;
      if (tc_seen != 1) begin
         $display("FAIL count_up_tc_pulses got=%0d exp=1", tc_seen);
         failures++;
      end
   endtask

   task automatic test_enable_hold();
      logic [5:0] e;
      repeat (4) begin
         cyc();
         checks++;
         if ({out1, tick1, tc1} !== {4'd1, 2'b00}) begin
            $display("FAIL hold_pre got=%h exp=%h", {out1, tick1, tc1}, {4'd1, 2'b00});
            failures++;
         end
      end
      en1 = 1'b0;
      repeat (7) begin
         cyc();
         checks++;
         if ({out1, tick1, tc1} !== {4'd1, 2'b00}) begin
            $display("FAIL hold_frozen got=%h exp=%h", {out1, tick1, tc1}, {4'd1, 2'b00});
            failures++;
         end
      end
      en1 = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         e = (i == 6) ? {4'd2, 2'b10} : {4'd1, 2'b00};
         checks++;
         if ({out1, tick1, tc1} !== e) begin
            $display("FAIL hold_resume i=%0d got=%h exp=%h", i, {out1, tick1, tc1}, e);
            failures++;
         end
      end
   endtask

   task automatic test_load();
      logic [5:0] e;
      repeat (9) cyc();
      load1 = 1'b1; lv1 = 4'd5;
      cyc();
      load1 = 1'b0;
      checks++;
      if ({out1, tick1, tc1} !== {4'd5, 2'b00}) begin
         $display("FAIL load_over_step got=%h exp=%h", {out1, tick1, tc1}, {4'd5, 2'b00});
         failures++;
      end
      for (int i = 1; i <= 10; i++) begin
         cyc();
         e = (i == 10) ? {4'd6, 2'b10} : {4'd5, 2'b00};
         checks++;
         if ({out1, tick1, tc1} !== e) begin
            $display("FAIL load_next_step i=%0d got=%h exp=%h", i, {out1, tick1, tc1}, e);
            failures++;
         end
      end
      en1 = 1'b0; load1 = 1'b1; lv1 = 4'd15;
      cyc();
      load1 = 1'b0;
      checks++;
      if ({out1, tick1, tc1} !== {4'd15, 2'b00}) begin
         $display("FAIL load_no_en got=%h exp=%h", {out1, tick1, tc1}, {4'd15, 2'b00});
         failures++;
      end
      en1 = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         cyc();
         e = (i == 10) ? {4'd0, 2'b11} : ((i == 11) ? 6'h00 : {4'd15, 2'b00});
         checks++;
         if ({out1, tick1, tc1} !== e) begin
            $display("FAIL load_wrap i=%0d got=%h exp=%h", i, {out1, tick1, tc1}, e);
            failures++;
         end
      end
   endtask

   task automatic test_prescale1();
      logic [3:0] eo;
      logic       ec;
      eo = 4'd0;
      en2 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         ec = (eo == 4'd9);
         eo = ec ? 4'd0 : eo + 4'd1;
         checks++;
         if ({out2, tick2, tc2} !== {eo, 1'b1, ec}) begin
            $display("FAIL p1_up i=%0d got=%h exp=%h", i, {out2, tick2, tc2}, {eo, 1'b1, ec});
            failures++;
         end
      end
      en2 = 1'b0;
      cyc();
      checks++;
      if ({out2, tick2, tc2} !== {eo, 2'b00}) begin
         $display("FAIL p1_hold got=%h exp=%h", {out2, tick2, tc2}, {eo, 2'b00});
         failures++;
      end
`ifdef CNT_DOWN_EN
      load2 = 1'b1; lv2 = 4'd0;
      cyc();
      load2 = 1'b0;
      eo = 4'd0;
      up2 = 1'b0; en2 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cyc();
         ec = (eo == 4'd0);
         eo = ec ? 4'd9 : eo - 4'd1;
         checks++;
         if ({out2, tick2, tc2} !== {eo, 1'b1, ec}) begin
            $display("FAIL p1_down i=%0d got=%h exp=%h", i, {out2, tick2, tc2}, {eo, 1'b1, ec});
            failures++;
         end
      end
      en2 = 1'b0; up2 = 1'b1;
`endif
   endtask

   task automatic test_clamp();
      logic [3:0] vals [6] = '{4'd14, 4'd12, 4'd11, 4'd10, 4'd15, 4'd0};
      logic [3:0] exps [6] = '{4'd11, 4'd11, 4'd11, 4'd10, 4'd11, 4'd0};
      logic [5:0] e;
      for (int k = 0; k < 6; k++) begin
         load3 = 1'b1; lv3 = vals[k];
         cyc();
         checks++;
         if ({out3, tick3, tc3} !== {exps[k], 2'b00}) begin
            $display("FAIL clamp lv=%0d got=%h exp=%h", vals[k], {out3, tick3, tc3}, {exps[k], 2'b00});
            failures++;
         end
      end
      lv3 = 4'd11;
      cyc();
      load3 = 1'b0; en3 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         e = (i == 3) ? {4'd0, 2'b11} : {4'd11, 2'b00};
         checks++;
         if ({out3, tick3, tc3} !== e) begin
            $display("FAIL clamp_wrap i=%0d got=%h exp=%h", i, {out3, tick3, tc3}, e);
            failures++;
         end
      end
      en3 = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [5:0] e;
      load1 = 1'b1; lv1 = 4'd6; en1 = 1'b1;
      cyc();
      load1 = 1'b0;
      repeat (10) cyc();
      checks++;
      if ({out1, tick1, tc1} !== {4'd7, 2'b10}) begin
         $display("FAIL arst_pre got=%h exp=%h", {out1, tick1, tc1}, {4'd7, 2'b10});
         failures++;
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({out1, tick1, tc1} !== 6'h00) begin
         $display("FAIL arst_immediate got=%h exp=00", {out1, tick1, tc1});
         failures++;
      end
      cyc();
      checks++;
      if ({out1, tick1, tc1} !== 6'h00) begin
         $display("FAIL arst_held got=%h exp=00", {out1, tick1, tc1});
         failures++;
      end
      rst = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         e = (i == 10) ? {4'd1, 2'b10} : 6'h00;
         checks++;
         if ({out1, tick1, tc1} !== e) begin
            $display("FAIL arst_first_step i=%0d got=%h exp=%h", i, {out1, tick1, tc1}, e);
            failures++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_enable_hold();
      test_load();
      test_prescale1();
      test_clamp();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prescaled_cnt.md
PRESCALED_CNT -- requirements
Module: prescaled_cnt

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter width in bits (1..16).
REQ-002 The block SHALL have parameter PRESCALE, default 10, meaning clk cycles per count step (1..65535).
REQ-003 The block SHALL have parameter MODULO, default 16, meaning count range 0..MODULO-1 (2..2^WIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: prescaler/count enable.
REQ-007 The block SHALL have port up, input, 1 bit: direction, 1 = up, 0 = down (present only with CNT_DOWN_EN).
REQ-008 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 The block SHALL have port out, output, WIDTH bits: registered count value.
REQ-011 The block SHALL have port tick, output, 1 bit: registered one-clk pulse marking each count step.
REQ-012 The block SHALL have port tc, output, 1 bit: registered one-clk terminal-count (wrap) pulse.

Function
REQ-013 The design SHALL be single-clock; no derived or gated clocks; prescaling SHALL be done with an internal clock enable.
REQ-014 Internal prescaler pcnt SHALL count 0..PRESCALE-1, advancing by 1 per clk while en=1 and holding while en=0.
REQ-015 When en=1 and pcnt=PRESCALE-1, pcnt SHALL return to 0 and a step SHALL occur on that edge.
REQ-016 With PRESCALE=1, a step SHALL occur on every clk edge with en=1.
REQ-017 On a step, tick SHALL be 1 during the following clk cycle; otherwise tick SHALL be 0.
REQ-018 On an up step, out SHALL increment; from MODULO-1 it SHALL wrap to 0.
REQ-019 On a down step, out SHALL decrement; from 0 it SHALL wrap to MODULO-1.
REQ-020 tc SHALL be 1 for exactly the one clk cycle after a wrapping step, and 0 otherwise.
REQ-021 Latency from the stepping edge to out, tick and tc SHALL be zero extra cycles; all three update on the same edge.
REQ-022 load=1 SHALL, at the next edge, set out to load_val, clear pcnt to 0 and force tick=0 and tc=0, regardless of en.
REQ-023 load SHALL have priority over a simultaneous step.
REQ-024 A load_val >= MODULO SHALL load MODULO-1.
REQ-025 A change of up between steps SHALL take effect at the next step, with no glitch on out.
REQ-026 All arithmetic SHALL be modulo MODULO; out SHALL never hold a value >= MODULO.

Reset
REQ-027 rst=0 SHALL immediately, without a clock, force out=0, pcnt=0, tick=0 and tc=0.
REQ-028 An assertion of rst in mid-count or mid-prescale SHALL discard all progress.
REQ-029 After rst deasserts, the first step SHALL occur PRESCALE enabled cycles later.

Configuration
REQ-030 The macro CNT_DOWN_EN SHALL select bidirectional counting.
REQ-031 With CNT_DOWN_EN defined, the up port SHALL exist and the block SHALL behave per REQ-018 and REQ-019.
REQ-032 Without CNT_DOWN_EN, the up port SHALL be absent and the block SHALL count up only.

Verification
REQ-033 Scenario, defaults, en=1, up=1, 200 clks: out SHALL step every 10 clks as 0,1,...,15,0; tc SHALL pulse once, when out becomes 0.
REQ-034 Scenario, PRESCALE=1, MODULO=10, down, en=1: out SHALL go 0,9,8,...,1,0; tc SHALL pulse on the 0->9 step.
REQ-035 Scenario, en=0 for 7 clks mid-prescale: out and pcnt SHALL freeze; the remaining prescale count SHALL resume afterwards.
REQ-036 Scenario, load=1 with load_val=5 coinciding with a step: out SHALL be 5 and tick SHALL be 0; the next step SHALL come 10 clks later with out=6.
REQ-037 Scenario, MODULO=12, load_val=14: out SHALL be 11.
REQ-038 Scenario, rst pulsed low between clk edges at out=7: out SHALL be 0 asynchronously and tick/tc SHALL be 0.
